// File: rtl/gf256_row_normalize.sv
// gf256_row_normalize
// Buffers one matrix row of GF(256) tower-field bytes, captures the pivot
// byte, inverts it, then streams the row back out with every byte multiplied
// by the pivot inverse so that the pivot position leaves as 0x01.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a row (IDLE only); latches row_beats, pivot_idx
//   row_beats         row length in beats, 1..MAX_BEATS
//   pivot_idx         byte index of the pivot within the row
//   in_valid/in_ready/in_data      input beat handshake, byte 0 in bits [7:0]
//   out_valid/out_ready/out_data   normalised output beat handshake
//   out_last          final beat of the row
//   singular          pivot was zero (held from INV until next start)
//   busy              FSM not idle
//
// state  | meaning
// IDLE   | waiting for a legal start
// LOAD   | accepting row beats into the buffer, capturing the pivot byte
// INV    | one cycle: invert pivot, flag singular
// STREAM | emitting buffer beats multiplied by the pivot inverse

module gf256_row_normalize #(
    parameter int LANES     = 4,
    parameter int MAX_BEATS = 32,
    parameter int BW        = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BW:0]                   row_beats,
    input  logic [BW+$clog2(LANES)-1:0]   pivot_idx,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*LANES-1:0]            in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8*LANES-1:0]            out_data,
    output logic                          out_last,
    output logic                          singular,
    output logic                          busy
);

    localparam int LW = $clog2(LANES);
    localparam int PW = BW + LW;
    localparam int DW = 8 * LANES;
    localparam logic [BW:0] MAXB = (BW+1)'(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, LOAD, INV, STREAM} state_t;

    // ---------------------------------------------------------------
    // Tower-field arithmetic
    //   GF(4)   = GF(2)[t0]/(t0^2+t0+1),   element {a1,a0} = a1*t0+a0
    //   GF(16)  = GF(4)[t1]/(t1^2+t1+t0),  element {hi,lo} = hi*t1+lo
    //   GF(256) = GF(16)[t2]/(t2^2+t2+0x8)
    // ---------------------------------------------------------------
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic hh;
        hh = a[1] & b[1];
        return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
    endfunction

    // In GF(4) x^3 = 1 for x != 0, so the square is also the inverse.
    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        hh = gf4_mul(a[3:2], b[3:2]);
        return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_mul(hh, 2'b10) ^ gf4_mul(a[1:0], b[1:0])};
    endfunction

    // (h*x + l)^-1 = (h*x + (h+l)) / (h^2*c + h*l + l^2), c = reduction constant
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [1:0] d, di;
        d  = gf4_mul(gf4_sq(a[3:2]), 2'b10) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
        di = gf4_sq(d);
        return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
    endfunction

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, 4'h8) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    // Zero maps to 1 so a singular row passes through unchanged.
    function automatic logic [7:0] gf256_inv(input logic [7:0] a);
        logic [3:0] d, di;
        if (a == 8'h00)
            return 8'h01;
        d  = gf16_mul(gf16_mul(a[7:4], a[7:4]), 4'h8) ^ gf16_mul(a[7:4], a[3:0])
           ^ gf16_mul(a[3:0], a[3:0]);
        di = gf16_inv(d);
        return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
    endfunction

    // ---------------------------------------------------------------
    // State and storage
    // ---------------------------------------------------------------
    state_t          state;
    logic [BW:0]     rows_q;
    logic [PW-1:0]   pidx_q;
    logic [BW:0]     wr_cnt;
    logic [BW:0]     rd_cnt;
    logic [7:0]      pivot;
    logic [7:0]      inv_reg;
    logic [DW-1:0]   buffer [MAX_BEATS];

    logic [BW-1:0]   pidx_beat;
    logic [LW-1:0]   pidx_lane;
    logic [7:0]      pivot_byte;
    logic [DW-1:0]   rd_beat;
    logic [DW-1:0]   norm_beat;

    assign pidx_beat = pidx_q[PW-1:LW];
    assign pidx_lane = pidx_q[LW-1:0];
    assign rd_beat   = buffer[rd_cnt[BW-1:0]];

    always_comb begin
        pivot_byte = in_data[8*int'(pidx_lane) +: 8];
    end

    // One multiplier per lane, directly between buffer read and out_data.
    always_comb begin
        norm_beat = '0;
        for (int k = 0; k < LANES; k++)
            norm_beat[8*k +: 8] = gf256_mul(rd_beat[8*k +: 8], inv_reg);
    end

    // Row buffer: no reset, stale contents are never read back.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready)
            buffer[wr_cnt[BW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            singular  <= 1'b0;
            busy      <= 1'b0;
            rows_q    <= '0;
            pidx_q    <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            pivot     <= '0;
            inv_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && row_beats != '0 && row_beats <= MAXB) begin
                        rows_q   <= row_beats;
                        pidx_q   <= pivot_idx;
                        wr_cnt   <= '0;
                        pivot    <= '0;
                        singular <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // in_ready is held high for all of LOAD
                    if (in_valid) begin
                        if ({1'b0, pidx_beat} == wr_cnt)
                            pivot <= pivot_byte;
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == rows_q - 1'b1) begin
                            in_ready <= 1'b0;
                            state    <= INV;
                        end
                    end
                end
                INV: begin
                    inv_reg  <= gf256_inv(pivot);
                    singular <= (pivot == 8'h00);
                    rd_cnt   <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if ((!out_valid || out_ready) && rd_cnt != rows_q) begin
                        out_data  <= norm_beat;
                        out_valid <= 1'b1;
                        out_last  <= (rd_cnt == rows_q - 1'b1);
                        rd_cnt    <= rd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf256_row_normalize.sv
// Testbench for gf256_row_normalize: directed rows plus randomized rows with
// input gaps and output back-pressure, checked against a byte-level model.

module tb_gf256_row_normalize;

    localparam int LANES = 4;
    localparam int MAXB  = 32;
    localparam int BW    = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [BW:0] row_beats;
    logic [6:0]  pivot_idx;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        singular;
    logic        busy;

    always #5 clk = ~clk;

    gf256_row_normalize #(.LANES(LANES), .MAX_BEATS(MAXB), .BW(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_beats (row_beats),
        .pivot_idx (pivot_idx),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .singular  (singular),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference field model ----------------
    function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        // polynomial product of degree <= 2, then t0^2 -> t0 + 1
        logic c2, c1, c0;
        c2 = a[1] & b[1];
        c1 = (a[1] & b[0]) ^ (a[0] & b[1]);
        c0 = a[0] & b[0];
        r  = {c1 ^ c2, c0 ^ c2};
        return r;
    endfunction

    function automatic logic [3:0] m16(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] c2, c1, c0;
        c2 = m4(a[3:2], b[3:2]);
        c1 = m4(a[3:2], b[1:0]) ^ m4(a[1:0], b[3:2]);
        c0 = m4(a[1:0], b[1:0]);
        // t1^2 -> t1 + t0
        return {c1 ^ c2, c0 ^ m4(c2, 2'b10)};
    endfunction

    function automatic logic [7:0] m256(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] c2, c1, c0;
        c2 = m16(a[7:4], b[7:4]);
        c1 = m16(a[7:4], b[3:0]) ^ m16(a[3:0], b[7:4]);
        c0 = m16(a[3:0], b[3:0]);
        // t2^2 -> t2 + 0x8
        return {c1 ^ c2, c0 ^ m16(c2, 4'h8)};
    endfunction

    // Inverse by exhaustive search over the field.
    logic [7:0] inv_tab [256];

    task automatic build_inv();
        inv_tab[0] = 8'h01;
        for (int a = 1; a < 256; a++) begin
            inv_tab[a] = 8'h00;
            for (int b = 1; b < 256; b++)
                if (m256(a[7:0], b[7:0]) == 8'h01)
                    inv_tab[a] = b[7:0];
        end
    endtask

    // ---------------- output monitor ----------------
    logic [31:0] got_q [$];
    logic        got_l [$];
    bit          last_seen;
    int          rdy_pct = 100;
    logic [31:0] row_data [32];

    function automatic logic [31:0] gq(input int i);
        return (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        bit          prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        prev_stall = 0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, prev_d);
                    chk("stall_last", out_last, prev_l);
                end
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    got_l.push_back(out_last);
                    if (out_last) last_seen = 1;
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                prev_l     = out_last;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- row runner ----------------
    task automatic run_row(input int nb, input int pidx, input int gap_pct, input bit mid_start);
        logic [7:0]  pv, iv;
        logic [31:0] w, e;
        logic [31:0] exp_q [$];
        int          acc_n, cyc;
        bit          acc;

        pv = 8'h00;
        if (pidx < nb * LANES) begin
            w  = row_data[pidx / LANES];
            pv = w[8*(pidx % LANES) +: 8];
        end
        iv = inv_tab[pv];
        for (int b = 0; b < nb; b++) begin
            w = row_data[b];
            for (int k = 0; k < LANES; k++)
                e[8*k +: 8] = m256(w[8*k +: 8], iv);
            exp_q.push_back(e);
        end

        got_q.delete();
        got_l.delete();
        last_seen = 0;

        start     = 1'b1;
        row_beats = nb[BW:0];
        pivot_idx = pidx[6:0];
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("in_ready_load", in_ready, 1);

        acc_n = 0;
        cyc   = 0;
        while (acc_n < nb && cyc < 2000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? row_data[acc_n] : $urandom;
            if (mid_start && acc_n == nb / 2) begin
                start     = 1'b1;
                row_beats = 6'd3;
                pivot_idx = 7'd0;
            end else begin
                start = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) acc_n++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_count", acc_n, nb);
        chk("in_ready_after_load", in_ready, 0);
        chk("lat_inv", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_stream0", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_first", out_valid, 1);
        chk("singular", singular, (pv == 8'h00));

        cyc = 0;
        while (!last_seen && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("last_seen", last_seen, 1);
        chk("busy_fall", busy, 0);
        chk("valid_fall", out_valid, 0);

        chk("beat_count", got_q.size(), nb);
        for (int b = 0; b < nb && b < got_q.size(); b++) begin
            chk($sformatf("data%0d", b), got_q[b], exp_q[b]);
            chk($sformatf("last%0d", b), got_l[b], (b == nb - 1));
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_singular"}, singular, 0);
        chk({tag, "_out_last"}, out_last, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        row_beats = '0;
        pivot_idx = '0;
        build_inv();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("por");
        chk("por_out_data", out_data, 0);

        // illegal row lengths are ignored
        start = 1'b1; row_beats = 6'd0;
        @(posedge clk); #1;
        chk("start_len0_ignored", busy, 0);
        row_beats = 6'd33;
        @(posedge clk); #1;
        chk("start_len33_ignored", busy, 0);
        start = 1'b0;

        rdy_pct = 100;
        row_data[0] = 32'h00030201;
        run_row(1, 0, 0, 0);
        chk("t1_out", gq(0), 32'h00030201);

        run_row(1, 1, 0, 0);
        chk("t2_out", gq(0), 32'h00020103);

        row_data[0] = 32'h0F0F0F0F;
        row_data[1] = 32'h00000004;
        run_row(2, 4, 0, 0);
        chk("t3_beat1", gq(1), 32'h00000001);

        row_data[0] = 32'h11223344;
        run_row(1, 4, 0, 0);
        chk("t4_out", gq(0), 32'h11223344);
        chk("t4_singular", singular, 1);

        // gaps, back-pressure, ignored mid-row start
        for (int b = 0; b < 8; b++) row_data[b] = $urandom;
        rdy_pct = 50;
        run_row(8, $urandom_range(0, 31), 40, 1);

        // reset in LOAD after 3 of 8 beats
        rdy_pct = 100;
        start = 1'b1; row_beats = 6'd8; pivot_idx = 7'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        pulse_reset();
        reset_checks("rst_load");

        // reset in STREAM after 2 outputs, singular row so the flag must clear
        got_q.delete();
        got_l.delete();
        start = 1'b1; row_beats = 6'd8; pivot_idx = 7'd100;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cyc = 0;
        while (got_q.size() < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_stream_outputs_seen", (got_q.size() >= 2), 1);
        chk("rst_stream_singular_pre", singular, 1);
        pulse_reset();
        reset_checks("rst_stream");

        for (int b = 0; b < 8; b++) row_data[b] = $urandom;
        run_row(8, 9, 0, 0);

        // random rows, including pivots outside the row
        for (int r = 0; r < 6; r++) begin
            int nb;
            nb = $urandom_range(1, 32);
            for (int b = 0; b < nb; b++) row_data[b] = $urandom;
            rdy_pct = 70;
            run_row(nb, $urandom_range(0, 127), 30, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
